bfly_router_rr: RTL and testbench
=================================

Name: bfly_router_rr

Overview:
Parametrised radix-N routing primitive for butterfly TCDM interconnects, generalising the radix-2 router to Radix = 2, 4 or 8.
- Each input routes on the top log2(Radix) address bits, then shifts them out before forwarding to the next layer.
- Each output has an independent fair round-robin arbiter.
- Read responses return over a configurable fixed-latency pipeline with per-input response-valid tracking.
- Instances form one stage of a multi-layer butterfly between cores and SRAM banks.

Parameters:
Radix, 4, number of inputs = number of outputs; power of two, 2..8
AddWidth, 8, address bits still to be routed; must be >= log2(Radix)
ReqDataWidth, 32, request payload width (wdata, be, wen packed by the user)
RespDataWidth, 32, response payload width
RespLat, 1, cycles from output grant to rdata_i being valid; >= 1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_i  in  Radix  request per input
gnt_o  out  Radix  grant per input
add_i  in  Radix x AddWidth  address per input
data_i  in  Radix x ReqDataWidth  request payload per input
rdata_o  out  Radix x RespDataWidth  response data per input
rvalid_o  out  Radix  response valid per input
req_o  out  Radix  request per output
gnt_i  in  Radix  grant per output from downstream
add_o  out  Radix x AddWidth  shifted address per output
data_o  out  Radix x ReqDataWidth  payload per output
rdata_i  in  Radix x RespDataWidth  response data per output

Behaviour:
- One clock; reset is synchronous and active-high, on rst_i sampled at posedge clk_i.
- Let L = log2(Radix). Destination of input i: dst_i = add_i[i][AddWidth-1 -: L].
- Request path is fully combinational:
  - req_o[j] = OR over i of (req_i[i] && dst_i == j).
  - gnt_o[i] = req_i[i] && (i is winner of dst_i) && gnt_i[dst_i].
- Arbiter j picks, among requesting inputs with dst == j, the first index at or after rr_q[j], circularly.
- Forwarding for output j with winner w: add_o[j] = add_i[w] << L (zero-filled), data_o[j] = data_i[w].
- With no request at output j: add_o[j] and data_o[j] are '0.
- Pointer update: on req_o[j] && gnt_i[j], rr_q[j] <= (w+1) mod Radix. Otherwise rr_q[j] is held, so a stalled downstream does not rotate fairness.
- Losing inputs see gnt_o = 0 and must hold req/add/data. There is no buffering inside the router.
- Response pipeline: one per output j, RespLat stages deep, each stage holding {vld, idx[L-1:0]}.
  - Stage 0 loads {req_o[j] && gnt_i[j], w}.
  - Stages shift every cycle; there is no backpressure.
- When the last stage of output j is valid with idx = i: rvalid_o[i] = 1 and rdata_o[i] = rdata_i[j], both combinational from rdata_i.
- No response collisions occur: each input is granted on at most one output per cycle, and latency is uniform. Assertion: at most one valid last stage per idx.
- An input with no response that cycle has rvalid_o[i] = 0 and rdata_o[i] = '0.
- Reset values:
  - rr_q = 0 for all outputs; all pipeline vld = 0.
  - rvalid_o = 0, rdata_o = '0.
  - req_o, gnt_o, add_o and data_o follow the combinational request path.
- Reset mid-operation: in-flight responses are dropped (no rvalid_o), and pointers return to 0 on the next cycle.
- Requests during reset are still routed combinationally; upstream keeps req_i low during reset.
- Simultaneous grants to different outputs in one cycle are independent; all proceed in parallel.
- Elaboration check: Radix must be a power of two and AddWidth >= L; otherwise fatal.

Test Plan:
Settings for all cases: Radix=4, AddWidth=6, RespLat=1.
1. Routing: req_i=4'b0001, add_i[0]=6'b10_0101, gnt_i=4'b1111 -> req_o=4'b0100, add_o[2]=6'b01_0100, data_o[2]=data_i[0], gnt_o=4'b0001.
2. Round-robin conflict: inputs 1 and 3 both with dst 0, held for 3 cycles, rr_q[0]=0, gnt_i[0]=1 -> gnt_o = 0010, then 1000, then 0010; rr_q[0] = 2, then 0, then 2.
3. Backpressure: same as 2 with gnt_i[0]=0 for 2 cycles -> gnt_o=0, rr_q[0] holds at 0. When gnt_i rises, input 1 is granted first.
4. Response steering: input 2 granted at output 1 in cycle t, rdata_i[1]=32'hDEAD_BEEF in t+1 -> rvalid_o=4'b0100, rdata_o[2]=32'hDEAD_BEEF in t+1 only.
5. Full permutation: inputs 0..3 with dst 3,2,1,0 simultaneously -> all four granted in one cycle. Responses return to the correct inputs one cycle later with distinct data.
6. Reset mid-flight: grant in cycle t, rst_i=1 in t -> no rvalid_o in t+1, and all rr_q = 0 afterwards.

Source files
------------

// File: rtl/bfly_router_rr_if.sv
// Port bundle for one radix-N butterfly router stage: upstream request/response
// side (_i/_o seen from the router) and downstream side toward the next layer.
interface bfly_router_rr_if #(
    parameter int unsigned Radix         = 4,
    parameter int unsigned AddWidth      = 8,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32
);
    logic [Radix-1:0]                    req_i;
    logic [Radix-1:0]                    gnt_o;
    logic [Radix-1:0][AddWidth-1:0]      add_i;
    logic [Radix-1:0][ReqDataWidth-1:0]  data_i;
    logic [Radix-1:0][RespDataWidth-1:0] rdata_o;
    logic [Radix-1:0]                    rvalid_o;
    logic [Radix-1:0]                    req_o;
    logic [Radix-1:0]                    gnt_i;
    logic [Radix-1:0][AddWidth-1:0]      add_o;
    logic [Radix-1:0][ReqDataWidth-1:0]  data_o;
    logic [Radix-1:0][RespDataWidth-1:0] rdata_i;

    modport slave (
        input  req_i, add_i, data_i, gnt_i, rdata_i,
        output gnt_o, rdata_o, rvalid_o, req_o, add_o, data_o
    );

    modport master (
        output req_i, add_i, data_i, gnt_i, rdata_i,
        input  gnt_o, rdata_o, rvalid_o, req_o, add_o, data_o
    );
endinterface

// File: rtl/bfly_router_rr.sv
// Radix-N butterfly router stage: per-output round-robin arbitration on the top
// log2(Radix) address bits, combinational forwarding, fixed-latency response return.
module bfly_router_rr #(
    parameter int unsigned Radix         = 4,
    parameter int unsigned AddWidth      = 8,
    parameter int unsigned ReqDataWidth  = 32,
    parameter int unsigned RespDataWidth = 32,
    parameter int unsigned RespLat       = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    bfly_router_rr_if.slave bus
);
    localparam int unsigned L = (Radix > 1) ? $clog2(Radix) : 1;

    typedef logic [L-1:0] idx_t;
    typedef struct packed {
        logic vld;
        idx_t idx;
    } rsp_t;

    if (Radix < 2 || Radix > 8 || (Radix & (Radix - 1)) != 0 || AddWidth < L || RespLat < 1)
    begin : g_param_check
        $fatal(1, "bfly_router_rr: Radix must be a power of two in 2..8, AddWidth >= log2(Radix), RespLat >= 1");
    end

    idx_t [Radix-1:0]                    dst_c;
    logic [Radix-1:0][Radix-1:0]         match_c;  // [output][input]
    idx_t [Radix-1:0]                    win_c;
    logic [Radix-1:0]                    req_o_c;
    logic [Radix-1:0]                    fire_c;
    logic [Radix-1:0]                    gnt_o_c;
    logic [Radix-1:0][AddWidth-1:0]      add_o_c;
    logic [Radix-1:0][ReqDataWidth-1:0]  data_o_c;
    logic [Radix-1:0]                    rvalid_o_c;
    logic [Radix-1:0][RespDataWidth-1:0] rdata_o_c;
    logic                                rsp_collide_c;

    idx_t [Radix-1:0]              rr_q, rr_d;
    rsp_t [Radix-1:0][RespLat-1:0] pipe_q, pipe_d;

    // Destination decode and per-output request matrix
    always_comb begin
        dst_c   = '0;
        match_c = '0;
        req_o_c = '0;
        for (int unsigned i = 0; i < Radix; i++) begin
            dst_c[i] = bus.add_i[i][AddWidth-1 -: L];
        end
        for (int unsigned j = 0; j < Radix; j++) begin
            for (int unsigned i = 0; i < Radix; i++) begin
                match_c[j][i] = bus.req_i[i] && (dst_c[i] == idx_t'(j));
            end
            req_o_c[j] = |match_c[j];
        end
    end

    // Round-robin pick: first requester at or after rr_q[j], circularly
    always_comb begin : p_arb
        idx_t cand;
        logic found;
        cand  = '0;
        found = 1'b0;
        win_c = '0;
        for (int unsigned j = 0; j < Radix; j++) begin
            found = 1'b0;
            for (int unsigned k = 0; k < Radix; k++) begin
                cand = rr_q[j] + idx_t'(k);
                if (!found && match_c[j][cand]) begin
                    win_c[j] = cand;
                    found    = 1'b1;
                end
            end
        end
    end

    // Forwarding, upstream grants and next-state for pointers and response pipe
    always_comb begin
        add_o_c  = '0;
        data_o_c = '0;
        fire_c   = '0;
        gnt_o_c  = '0;
        rr_d     = rr_q;
        pipe_d   = '0;
        for (int unsigned j = 0; j < Radix; j++) begin
            if (req_o_c[j]) begin
                add_o_c[j]  = bus.add_i[win_c[j]] << L;
                data_o_c[j] = bus.data_i[win_c[j]];
            end
            fire_c[j] = req_o_c[j] && bus.gnt_i[j];
            if (fire_c[j]) begin
                gnt_o_c[win_c[j]] = 1'b1;
                rr_d[j]           = win_c[j] + idx_t'(1);
            end
            pipe_d[j][0] = '{vld: fire_c[j], idx: win_c[j]};
            for (int unsigned s = 1; s < RespLat; s++) begin
                pipe_d[j][s] = pipe_q[j][s-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q   <= '0;
            pipe_q <= '0;
        end else begin
            rr_q   <= rr_d;
            pipe_q <= pipe_d;
        end
    end

    // Steer returning rdata back to the input that issued the request
    always_comb begin
        rvalid_o_c    = '0;
        rdata_o_c     = '0;
        rsp_collide_c = 1'b0;
        for (int unsigned j = 0; j < Radix; j++) begin
            if (pipe_q[j][RespLat-1].vld) begin
                if (rvalid_o_c[pipe_q[j][RespLat-1].idx]) begin
                    rsp_collide_c = 1'b1;
                end
                rvalid_o_c[pipe_q[j][RespLat-1].idx] = 1'b1;
                rdata_o_c[pipe_q[j][RespLat-1].idx]  = bus.rdata_i[j];
            end
        end
    end

    a_no_rsp_collision: assert property (@(posedge clk_i) disable iff (rst_i) !rsp_collide_c);

    assign bus.req_o    = req_o_c;
    assign bus.gnt_o    = gnt_o_c;
    assign bus.add_o    = add_o_c;
    assign bus.data_o   = data_o_c;
    assign bus.rvalid_o = rvalid_o_c;
    assign bus.rdata_o  = rdata_o_c;

endmodule

// File: tb/tb_bfly_router_rr.sv
// Directed bench for bfly_router_rr (Radix=4, AddWidth=6, RespLat=1): a table of
// combinational routing vectors plus hand-written multi-cycle arbitration/response sequences.
module tb_bfly_router_rr;
    localparam int unsigned RADIX = 4;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 32;

    localparam logic [31:0] D0 = 32'hA0A0_0000;
    localparam logic [31:0] D1 = 32'hB1B1_0001;
    localparam logic [31:0] D2 = 32'hC2C2_0002;
    localparam logic [31:0] D3 = 32'hD3D3_0003;
    localparam logic [3:0][31:0] DIN = {D3, D2, D1, D0};

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bfly_router_rr_if #(.Radix(RADIX), .AddWidth(AW), .ReqDataWidth(DW), .RespDataWidth(DW)) bus ();

    bfly_router_rr #(
        .Radix(RADIX), .AddWidth(AW), .ReqDataWidth(DW), .RespDataWidth(DW), .RespLat(1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        string            name;
        logic [3:0]       req;
        logic [3:0][5:0]  add;
        logic [3:0]       gnt_dn;
        logic [3:0]       e_req;
        logic [3:0]       e_gnt;
        logic [3:0][5:0]  e_add;
        logic [3:0][31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_i   = '0;
        bus.add_i   = '0;
        bus.data_i  = DIN;
        bus.gnt_i   = '0;
        bus.rdata_i = '0;
    endtask

    // Leaves the bench at posedge+1 with reset released and rr pointers at 0
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] req, input logic [3:0][5:0] add,
                                input logic [3:0] gnt_dn, input logic [3:0] e_req, input logic [3:0] e_gnt,
                                input logic [3:0][5:0] e_add, input logic [3:0][31:0] e_data);
        vec_t v;
        v.name = name; v.req = req; v.add = add; v.gnt_dn = gnt_dn;
        v.e_req = e_req; v.e_gnt = e_gnt; v.e_add = e_add; v.e_data = e_data;
        return v;
    endfunction

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_g [3];
        logic [1:0] exp_r [3];

        vecs.push_back(mk("route_single", 4'b0001, {6'd0, 6'd0, 6'd0, 6'b100101}, 4'b1111,
                          4'b0100, 4'b0001, {6'd0, 6'b010100, 6'd0, 6'd0}, {32'd0, D0, 32'd0, 32'd0}));
        vecs.push_back(mk("permutation", 4'b1111, {6'b001010, 6'b011111, 6'b100001, 6'b110011}, 4'b1111,
                          4'b1111, 4'b1111, {6'b001100, 6'b000100, 6'b111100, 6'b101000}, {D0, D1, D2, D3}));
        vecs.push_back(mk("conflict_rr0", 4'b1010, {6'b001001, 6'd0, 6'b000111, 6'd0}, 4'b0001,
                          4'b0001, 4'b0010, {6'd0, 6'd0, 6'd0, 6'b011100}, {32'd0, 32'd0, 32'd0, D1}));
        vecs.push_back(mk("conflict_stall", 4'b1010, {6'b001001, 6'd0, 6'b000111, 6'd0}, 4'b0000,
                          4'b0001, 4'b0000, {6'd0, 6'd0, 6'd0, 6'b011100}, {32'd0, 32'd0, 32'd0, D1}));
        vecs.push_back(mk("no_request", 4'b0000, {6'b111111, 6'b101010, 6'b010101, 6'b110000}, 4'b1111,
                          4'b0000, 4'b0000, '0, '0));
        vecs.push_back(mk("all_to_out2", 4'b1111, {6'b100011, 6'b100010, 6'b100001, 6'b101100}, 4'b0100,
                          4'b0100, 4'b0001, {6'd0, 6'b110000, 6'd0, 6'd0}, {32'd0, D0, 32'd0, 32'd0}));
        vecs.push_back(mk("two_pairs", 4'b1111, {6'b111111, 6'b011000, 6'b110110, 6'b010001}, 4'b1000,
                          4'b1010, 4'b0010, {6'b011000, 6'd0, 6'b000100, 6'd0}, {D1, 32'd0, D0, 32'd0}));

        // Reset state
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #3;
        chk("reset_rvalid", 128'(bus.rvalid_o), 128'(4'b0000));
        chk("reset_rdata", 128'(bus.rdata_o), 128'd0);
        chk("reset_rr", 128'(dut.rr_q), 128'd0);
        chk("reset_req_o", 128'(bus.req_o), 128'(4'b0000));

        // Combinational routing table, each vector from a fresh reset
        foreach (vecs[n]) begin
            do_reset();
            bus.req_i = vecs[n].req;
            bus.add_i = vecs[n].add;
            bus.gnt_i = vecs[n].gnt_dn;
            #3;
            chk({vecs[n].name, ".req_o"},  128'(bus.req_o),  128'(vecs[n].e_req));
            chk({vecs[n].name, ".gnt_o"},  128'(bus.gnt_o),  128'(vecs[n].e_gnt));
            chk({vecs[n].name, ".add_o"},  128'(bus.add_o),  128'(vecs[n].e_add));
            chk({vecs[n].name, ".data_o"}, 128'(bus.data_o), 128'(vecs[n].e_data));
        end

        // Round-robin alternation with inputs 1 and 3 contending for output 0
        do_reset();
        exp_g = '{4'b0010, 4'b1000, 4'b0010};
        exp_r = '{2'd2, 2'd0, 2'd2};
        bus.req_i = 4'b1010;
        bus.add_i = {6'b001001, 6'd0, 6'b000111, 6'd0};
        bus.gnt_i = 4'b0001;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk($sformatf("rr_gnt_c%0d", c), 128'(bus.gnt_o), 128'(exp_g[c]));
            if (c > 0) chk($sformatf("rr_rvalid_c%0d", c), 128'(bus.rvalid_o), 128'(exp_g[c-1]));
            @(posedge clk);
            #1;
            chk($sformatf("rr_ptr_c%0d", c), 128'(dut.rr_q[0]), 128'(exp_r[c]));
        end

        // Downstream stall must not rotate the pointer
        do_reset();
        bus.req_i = 4'b1010;
        bus.add_i = {6'b001001, 6'd0, 6'b000111, 6'd0};
        bus.gnt_i = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            #3;
            chk($sformatf("stall_gnt_c%0d", c), 128'(bus.gnt_o), 128'(4'b0000));
            @(posedge clk);
            #1;
            chk($sformatf("stall_ptr_c%0d", c), 128'(dut.rr_q[0]), 128'(2'd0));
        end
        bus.gnt_i = 4'b0001;
        #3;
        chk("stall_release_gnt", 128'(bus.gnt_o), 128'(4'b0010));
        @(posedge clk);
        #1;
        chk("stall_release_ptr", 128'(dut.rr_q[0]), 128'(2'd2));

        // Response steering: input 2 via output 1
        do_reset();
        bus.req_i = 4'b0100;
        bus.add_i = {6'd0, 6'b010110, 6'd0, 6'd0};
        bus.gnt_i = 4'b0010;
        #3;
        chk("steer_gnt_t", 128'(bus.gnt_o), 128'(4'b0100));
        chk("steer_rvalid_t", 128'(bus.rvalid_o), 128'(4'b0000));
        @(posedge clk);
        #1;
        idle_inputs();
        bus.rdata_i = {32'd0, 32'd0, 32'hDEAD_BEEF, 32'd0};
        #3;
        chk("steer_rvalid_t1", 128'(bus.rvalid_o), 128'(4'b0100));
        chk("steer_rdata_t1", 128'(bus.rdata_o), 128'({32'd0, 32'hDEAD_BEEF, 32'd0, 32'd0}));
        @(posedge clk);
        #4;
        chk("steer_rvalid_t2", 128'(bus.rvalid_o), 128'(4'b0000));
        chk("steer_rdata_t2", 128'(bus.rdata_o), 128'd0);

        // Full permutation: all granted together, responses return crosswise
        do_reset();
        bus.req_i = 4'b1111;
        bus.add_i = {6'b001010, 6'b011111, 6'b100001, 6'b110011};
        bus.gnt_i = 4'b1111;
        #3;
        chk("perm_gnt", 128'(bus.gnt_o), 128'(4'b1111));
        @(posedge clk);
        #1;
        idle_inputs();
        bus.rdata_i = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        #3;
        chk("perm_rvalid", 128'(bus.rvalid_o), 128'(4'b1111));
        chk("perm_rdata", 128'(bus.rdata_o),
            128'({32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003}));
        @(posedge clk);
        #4;
        chk("perm_rvalid_after", 128'(bus.rvalid_o), 128'(4'b0000));

        // Reset with a grant in flight drops the response and clears pointers
        do_reset();
        bus.req_i = 4'b1010;
        bus.add_i = {6'b001001, 6'd0, 6'b000111, 6'd0};
        bus.gnt_i = 4'b0001;
        @(posedge clk);
        #1;
        chk("rstmid_ptr_pre", 128'(dut.rr_q[0]), 128'(2'd2));
        rst = 1'b1;
        #3;
        chk("rstmid_gnt_in_reset", 128'(bus.gnt_o), 128'(4'b1000));
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        bus.rdata_i = {32'h5555_AAAA, 32'h5555_AAAA, 32'h5555_AAAA, 32'h5555_AAAA};
        #3;
        chk("rstmid_rvalid", 128'(bus.rvalid_o), 128'(4'b0000));
        chk("rstmid_rdata", 128'(bus.rdata_o), 128'd0);
        chk("rstmid_ptr_all", 128'(dut.rr_q), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
